// File: rtl/qar_pwm.sv
// qar_pwm: two-channel PWM timer on the QAR MMIO bus (word addressed).
// A shared prescaler and period counter drive two compare channels. PERIOD and
// DUTYn writes go to pending registers. The active copies reload from them at
// each period wrap, which keeps the outputs glitch-free.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   write_en, read_en   register write / read strobes
//   addr_word [4:0]     register word offset
//   wdata [31:0]        write data
//   rdata [31:0]        combinational read data (0 if not reading or unmapped)
//   pwm0, pwm1          registered PWM outputs
//   irq                 wrap interrupt, IRQ_EN & IRQ_STATUS
module qar_pwm #(
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned PRESC_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write_en,
    input  logic        read_en,
    input  logic [4:0]  addr_word,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        pwm0,
    output logic        pwm1,
    output logic        irq
);

    logic                   en_q, inv0_q, inv1_q;
    logic [PRESC_WIDTH-1:0] presc_q, pcnt_q;
    logic [CNT_WIDTH-1:0]   period_q, duty0_q, duty1_q;
    logic [CNT_WIDTH-1:0]   top_act_q, duty0_act_q, duty1_act_q, cnt_q;
    logic                   irq_en_q, irq_sts_q, irq_sts_d;
    logic                   pwm0_q, pwm1_q;
    logic                   tick, wrap, load_shadow, clr_sts;

    // Upper write-data bits beyond each field are ignored.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    assign tick        = en_q && (pcnt_q == presc_q);
    assign wrap        = tick && (cnt_q == top_act_q);
    // Reloading every cycle while disabled makes configuration before enable immediate.
    assign load_shadow = wrap || !en_q;
    assign clr_sts     = write_en && (addr_word == 5'd7) && wdata[0];

    // Programmable registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q     <= 1'b0;
            inv0_q   <= 1'b0;
            inv1_q   <= 1'b0;
            presc_q  <= '0;
            period_q <= '0;
            duty0_q  <= '0;
            duty1_q  <= '0;
            irq_en_q <= 1'b0;
        end else if (write_en) begin
            case (addr_word)
                5'd0: begin
                    en_q   <= wdata[0];
                    inv0_q <= wdata[1];
                    inv1_q <= wdata[2];
                end
                5'd1:    presc_q  <= wdata[PRESC_WIDTH-1:0];
                5'd2:    period_q <= wdata[CNT_WIDTH-1:0];
                5'd3:    duty0_q  <= wdata[CNT_WIDTH-1:0];
                5'd4:    duty1_q  <= wdata[CNT_WIDTH-1:0];
                5'd6:    irq_en_q <= wdata[0];
                default: ;
            endcase
        end
    end

    // A wrap in the same cycle as a write-1-to-clear keeps the flag set.
    always_comb begin
        irq_sts_d = irq_sts_q;
        if (clr_sts) irq_sts_d = 1'b0;
        if (wrap)    irq_sts_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_sts_q <= 1'b0;
        else        irq_sts_q <= irq_sts_d;
    end

    // Active copies. A pending write on the wrap cycle is not visible here
    // until the following wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_act_q   <= '0;
            duty0_act_q <= '0;
            duty1_act_q <= '0;
        end else if (load_shadow) begin
            top_act_q   <= period_q;
            duty0_act_q <= duty0_q;
            duty1_act_q <= duty1_q;
        end
    end

    // Prescaler and period counter are held at zero while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
            cnt_q  <= '0;
        end else if (!en_q) begin
            pcnt_q <= '0;
            cnt_q  <= '0;
        end else if (tick) begin
            pcnt_q <= '0;
            cnt_q  <= wrap ? '0 : cnt_q + CNT_WIDTH'(1);
        end else begin
            pcnt_q <= pcnt_q + PRESC_WIDTH'(1);
        end
    end

    // Outputs lag the counter by one clock. When disabled they sit at the INVn idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm0_q <= 1'b0;
            pwm1_q <= 1'b0;
        end else begin
            pwm0_q <= (en_q && (cnt_q < duty0_act_q)) ^ inv0_q;
            pwm1_q <= (en_q && (cnt_q < duty1_act_q)) ^ inv1_q;
        end
    end

    assign pwm0 = pwm0_q;
    assign pwm1 = pwm1_q;
    assign irq  = irq_en_q & irq_sts_q;

    always_comb begin
        rdata = '0;
        if (read_en) begin
            case (addr_word)
                5'd0:    rdata = {29'd0, inv1_q, inv0_q, en_q};
                5'd1:    rdata = 32'(presc_q);
                5'd2:    rdata = 32'(period_q);
                5'd3:    rdata = 32'(duty0_q);
                5'd4:    rdata = 32'(duty1_q);
                5'd5:    rdata = 32'(cnt_q);
                5'd6:    rdata = {31'd0, irq_en_q};
                5'd7:    rdata = {31'd0, irq_sts_q};
                default: rdata = '0;
            endcase
        end
    end

endmodule
